// File: rtl/mem_access.sv
// PSRV32 memory stage: one req/ack data-memory transaction per load/store, ALU results pass through.
// Optional bus timeout abort is built when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_access #(
  parameter int unsigned XLEN = 32
`ifdef MEM_ACCESS_TIMEOUT_EN
  , parameter int unsigned MAX_WAIT = 15
`endif
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] read_data2_i,
  input  logic [4:0]      write_reg_i,
  input  logic            regwrite_i,
  input  logic            memread_i,
  input  logic            memwrite_i,
  input  logic [2:0]      funct3_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            valid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      write_reg_o,
  output logic            regwrite_o,
  output logic            misalign_o,
  output logic            fault_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [4:0]        rd_q, rd_d, write_reg_q, write_reg_d;
  logic              rw_q, rw_d;
  logic              valid_q, valid_d, regwrite_q, regwrite_d;
  logic              misalign_q, misalign_d, fault_q, fault_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
`endif

  logic              is_mem, illegal, misal, bad_load_f3, bad_store_f3;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   wdata_c, lane_data, load_ext;

  // Request decode: legality, alignment, byte lanes and replicated store data
  always_comb begin
    is_mem       = memread_i | memwrite_i;
    bad_load_f3  = (funct3_i == 3'b011) | (funct3_i == 3'b110) | (funct3_i == 3'b111);
    bad_store_f3 = funct3_i[2] | (funct3_i[1:0] == 2'b11);
    illegal      = (memread_i & memwrite_i) | (memread_i & bad_load_f3) |
                   (memwrite_i & bad_store_f3);
    misal        = ((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                   ((funct3_i[1:0] == 2'b10) & (|alu_result_i[1:0]));
    case (funct3_i[1:0])
      2'b00: begin
        be_c    = 4'(4'b0001 << alu_result_i[1:0]);
        wdata_c = XLEN'({4{read_data2_i[7:0]}});
      end
      2'b01: begin
        be_c    = 4'(4'b0011 << alu_result_i[1:0]);
        wdata_c = XLEN'({2{read_data2_i[15:0]}});
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = read_data2_i;
      end
    endcase
  end

  // Load lane select and sign/zero extension
  assign lane_data = dmem_rdata_i >> {lane_q, 3'b000};
  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{(XLEN-8){lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_ext = {{(XLEN-16){lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane_data[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane_data[15:0]};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    wb_data_d   = wb_data_q;
    write_reg_d = write_reg_q;
    valid_d     = 1'b0;
    regwrite_d  = 1'b0;
    misalign_d  = 1'b0;
    fault_d     = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          write_reg_d = write_reg_i;
          if (!is_mem) begin
            valid_d    = 1'b1;
            wb_data_d  = alu_result_i;
            regwrite_d = regwrite_i;
          end else if (illegal) begin
            valid_d   = 1'b1;
            fault_d   = 1'b1;
            wb_data_d = '0;
          end else if (misal) begin
            valid_d    = 1'b1;
            misalign_d = 1'b1;
            wb_data_d  = '0;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = memwrite_i;
            addr_d  = {alu_result_i[XLEN-1:2], 2'b00};
            be_d    = be_c;
            wdata_d = wdata_c;
            f3_d    = funct3_i;
            lane_d  = alu_result_i[1:0];
            rd_d    = write_reg_i;
            rw_d    = regwrite_i;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      BUSY: begin
        if (dmem_ack_i) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          valid_d     = 1'b1;
          write_reg_d = rd_q;
          wb_data_d   = we_q ? '0 : load_ext;
          regwrite_d  = we_q ? 1'b0 : rw_q;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          valid_d     = 1'b1;
          fault_d     = 1'b1;
          write_reg_d = rd_q;
          wb_data_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      valid_q     <= 1'b0;
      wb_data_q   <= '0;
      write_reg_q <= '0;
      regwrite_q  <= 1'b0;
      misalign_q  <= 1'b0;
      fault_q     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      valid_q     <= valid_d;
      wb_data_q   <= wb_data_d;
      write_reg_q <= write_reg_d;
      regwrite_q  <= regwrite_d;
      misalign_q  <= misalign_d;
      fault_q     <= fault_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // ready is held low while reset is asserted so it rises with deassertion
  assign ready_o      = reset_i & (state_q == IDLE);
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign valid_o      = valid_q;
  assign wb_data_o    = wb_data_q;
  assign write_reg_o  = write_reg_q;
  assign regwrite_o   = regwrite_q;
  assign misalign_o   = misalign_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected WB results and bus requests,
// independent monitors pop and compare when the DUT presents them.
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        reset_i, valid_i, ready_o;
  logic [31:0] alu_result_i, read_data2_i;
  logic [4:0]  write_reg_i;
  logic        regwrite_i, memread_i, memwrite_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  write_reg_o;
  logic        regwrite_o, misalign_o, fault_o;

  mem_access dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .alu_result_i(alu_result_i), .read_data2_i(read_data2_i), .write_reg_i(write_reg_i),
    .regwrite_i(regwrite_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .funct3_i(funct3_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
    .wb_data_o(wb_data_o), .write_reg_o(write_reg_o), .regwrite_o(regwrite_o),
    .misalign_o(misalign_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw, mis, flt, chk_data;
    int unsigned due;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int unsigned hold;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // WB monitor
  wb_exp_t we_cur;
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      if (wb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid: got valid_o=1 wb_data=%0h, expected no result (cycle %0d)",
                 wb_data_o, cyc);
      end else begin
        we_cur = wb_q.pop_front();
        check("valid_cycle", 32'(cyc), 32'(we_cur.due));
        check("regwrite", 32'(regwrite_o), 32'(we_cur.rw));
        check("misalign", 32'(misalign_o), 32'(we_cur.mis));
        check("fault", 32'(fault_o), 32'(we_cur.flt));
        if (we_cur.chk_data) begin
          check("wb_data", wb_data_o, we_cur.wb);
          check("write_reg", 32'(write_reg_o), 32'(we_cur.rd));
        end
      end
    end
  end

  // Bus monitor: fields checked on every request cycle, hold length on release
  bus_exp_t    bus_cur;
  logic        in_txn = 1'b0;
  logic        bogus  = 1'b0;
  int unsigned hold_cnt = 0;
  always @(negedge clk_i) begin
    if (dmem_req_o === 1'b1) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        hold_cnt = 0;
        if (bus_q.size() == 0) begin
          bogus = 1'b1;
          tests++; fails++;
          $display("FAIL unexpected_req: got req addr=%0h, expected no request (cycle %0d)",
                   dmem_addr_o, cyc);
        end else begin
          bogus   = 1'b0;
          bus_cur = bus_q.pop_front();
        end
      end
      hold_cnt++;
      if (!bogus) begin
        check("bus_we", 32'(dmem_we_o), 32'(bus_cur.we));
        check("bus_addr", dmem_addr_o, bus_cur.addr);
        check("bus_be", 32'(dmem_be_o), 32'(bus_cur.be));
        if (bus_cur.we) check("bus_wdata", dmem_wdata_o, bus_cur.wdata);
      end
    end else if (in_txn) begin
      if (!bogus) check("req_hold", 32'(hold_cnt), 32'(bus_cur.hold));
      in_txn = 1'b0;
      bogus  = 1'b0;
    end
  end

  task automatic exp_wb(input int unsigned lat, input logic [31:0] wb, input logic [4:0] rd,
                        input logic rw, input logic mis, input logic flt, input logic chk);
    wb_exp_t e;
    e.wb = wb; e.rd = rd; e.rw = rw; e.mis = mis; e.flt = flt; e.chk_data = chk; e.due = cyc + lat;
    wb_q.push_back(e);
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int unsigned hold);
    bus_exp_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.hold = hold;
    bus_q.push_back(b);
  endtask

  // Present one instruction for a single cycle; caller is at a negedge with ready_o high
  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    if (ready_o !== 1'b1) begin
      tests++; fails++;
      $display("FAIL ready_before_issue: got ready_o=%b, expected 1 (cycle %0d)", ready_o, cyc);
    end
    alu_result_i = alu; read_data2_i = rs2; write_reg_i = rd; regwrite_i = rw;
    memread_i = mr; memwrite_i = mw; funct3_i = f3; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0; regwrite_i = 1'b0;
  endtask

  // Acknowledge the outstanding request d cycles after it first appears
  task automatic ack_after(input int unsigned d, input logic [31:0] rdata);
    int unsigned n = 0;
    while (dmem_req_o !== 1'b1 && n < 40) begin @(negedge clk_i); n++; end
    if (dmem_req_o !== 1'b1) begin
      tests++; fails++;
      $display("FAIL req_wait: got req_o=%b, expected 1 within 40 cycles", dmem_req_o);
      return;
    end
    repeat (d - 1) @(negedge clk_i);
    dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
    @(negedge clk_i);
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h5A5A_5A5A;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish before 200000 time units");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b0; valid_i = 1'b0; alu_result_i = '0; read_data2_i = '0; write_reg_i = '0;
    regwrite_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0; funct3_i = '0;
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h5A5A_5A5A;
    #1;
    check("rst_ready", 32'(ready_o), 32'h0);
    check("rst_req", 32'(dmem_req_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_flags", {29'h0, regwrite_o, misalign_o, fault_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    #1 check("ready_after_reset", 32'(ready_o), 32'h1);
    @(negedge clk_i);

    // ALU passthrough, then two back-to-back
    exp_wb(1, 32'h1234_5678, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(32'h1234_5678, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
    exp_wb(1, 32'hFFFF_0001, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(32'hFFFF_0001, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 3'b000);

    // LW 0x100, ack 3 cycles after req
    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 3);
    exp_wb(4, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010);
    ack_after(3, 32'hDEAD_BEEF);

    // SB 0x103
    exp_bus(1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB, 1);
    exp_wb(2, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(32'h103, 32'h0000_00AB, 5'd9, 1'b0, 1'b0, 1'b1, 3'b000);
    ack_after(1, 32'h0);

    // SH 0x102, SW 0x204
    exp_bus(1'b1, 32'h100, 4'b1100, 32'hBEEF_BEEF, 2);
    exp_wb(3, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(32'h102, 32'h1234_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);
    ack_after(2, 32'h0);
    exp_bus(1'b1, 32'h204, 4'b1111, 32'hCAFE_F00D, 1);
    exp_wb(2, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(32'h204, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
    ack_after(1, 32'h0);

    // LB / LBU / LHU / LH at 0x102
    exp_bus(1'b0, 32'h100, 4'b0100, 32'h0, 2);
    exp_wb(3, 32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(32'h102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
    ack_after(2, 32'h0080_0000);
    exp_bus(1'b0, 32'h100, 4'b0100, 32'h0, 1);
    exp_wb(2, 32'h0000_0080, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b100);
    ack_after(1, 32'h0080_0000);
    exp_bus(1'b0, 32'h100, 4'b1100, 32'h0, 1);
    exp_wb(2, 32'h0000_8001, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(32'h102, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b101);
    ack_after(1, 32'h8001_0000);
    exp_bus(1'b0, 32'h100, 4'b1100, 32'h0, 1);
    exp_wb(2, 32'hFFFF_FFFE, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(32'h102, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b001);
    ack_after(1, 32'hFFFE_0000);

    // Misaligned: LH 0x101, LW 0x102 -- no request
    exp_wb(1, 32'h0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'h101, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b001);
    exp_wb(1, 32'h0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(32'h102, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 3'b010);

    // Illegal: load f3=011, store f3=100, load+store together
    exp_wb(1, 32'h0, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(32'h100, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 3'b011);
    exp_wb(1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(32'h100, 32'h11, 5'd0, 1'b0, 1'b0, 1'b1, 3'b100);
    exp_wb(1, 32'h0, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(32'h100, 32'h11, 5'd15, 1'b1, 1'b1, 1'b1, 3'b010);

    // Ack while idle must be ignored
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    @(negedge clk_i);
    check("idle_ack_no_req", 32'(dmem_req_o), 32'h0);
    check("idle_ack_no_valid", 32'(valid_o), 32'h0);

    // Reset during BUSY: request drops at once, no result
    exp_bus(1'b0, 32'h300, 4'b1111, 32'h0, 2);
    drive(32'h300, 32'h0, 5'd16, 1'b1, 1'b1, 1'b0, 3'b010);
    @(negedge clk_i);
    #2 reset_i = 1'b0;
    #1;
    check("reset_req_drop", 32'(dmem_req_o), 32'h0);
    check("reset_ready_low", 32'(ready_o), 32'h0);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    exp_wb(1, 32'h0000_0042, 5'd17, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(32'h0000_0042, 32'h0, 5'd17, 1'b1, 1'b0, 1'b0, 3'b000);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // No ack: abort after 15 BUSY cycles, then a late ack is ignored
    exp_bus(1'b0, 32'h400, 4'b1111, 32'h0, 15);
    exp_wb(16, 32'h0, 5'd18, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(32'h400, 32'h0, 5'd18, 1'b1, 1'b1, 1'b0, 3'b010);
    repeat (16) @(negedge clk_i);
    dmem_ack_i = 1'b1;
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
`endif

    repeat (5) @(negedge clk_i);
    check("wb_queue_drained", 32'(wb_q.size()), 32'h0);
    check("bus_queue_drained", 32'(bus_q.size()), 32'h0);
    check("no_open_txn", 32'(in_txn), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
